// File: rtl/lms_adapt_ctrl_pkg.sv
// rtl/lms_adapt_ctrl_pkg.sv - shared constants and state encoding for the LMS adaptation sequencer
package lms_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_TRACK = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int          NB_DATA_DEF   = 16;
  localparam int          NB_CNT_DEF    = 16;
  localparam int          TRAIN_LEN_DEF = 4096;
  localparam int          ALPHA_SH_DEF  = 4;
  localparam int          DIV_CNT_DEF   = 64;

  // Q1.15 step sizes and error-power thresholds
  localparam logic [15:0] MU_TRAIN_DEF  = 16'h0666;
  localparam logic [15:0] MU_TRACK_DEF  = 16'h0148;
  localparam logic [15:0] DIV_THR_DEF   = 16'h4000;
  localparam logic [15:0] CONV_THR_DEF  = 16'h0400;

endpackage

// File: rtl/lms_adapt_ctrl_err_pow.sv
// rtl/lms_adapt_ctrl_err_pow.sv - leaky mean of |e| with saturation, updated on valid samples
module err_pow_est #(
  parameter int NB_DATA  = 16,
  parameter int ALPHA_SH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_error,
  output logic [NB_DATA-1:0] o_err_pow
);

  localparam logic [NB_DATA-1:0] P_MAX = {1'b0, {(NB_DATA-1){1'b1}}};

  logic        [NB_DATA:0]   mag_full;
  logic        [NB_DATA-1:0] mag;
  logic signed [NB_DATA+1:0] diff;
  logic signed [NB_DATA+1:0] step;
  logic signed [NB_DATA+1:0] sum;
  logic        [NB_DATA-1:0] pow_nx;

  // Most-negative input has no positive twin in NB_DATA bits, hence the extra bit and clamp
  always_comb begin
    mag_full = i_error[NB_DATA-1] ? (~{i_error[NB_DATA-1], i_error} + 1'b1)
                                  : {i_error[NB_DATA-1], i_error};
    mag      = (mag_full > {1'b0, P_MAX}) ? P_MAX : mag_full[NB_DATA-1:0];
    diff     = $signed({2'b00, mag}) - $signed({2'b00, o_err_pow});
    step     = diff >>> ALPHA_SH;
    sum      = $signed({2'b00, o_err_pow}) + step;
    if (sum < 0)
      pow_nx = '0;
    else if (sum > $signed({2'b00, P_MAX}))
      pow_nx = P_MAX;
    else
      pow_nx = sum[NB_DATA-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_err_pow <= '0;
    else if (i_valid)
      o_err_pow <= pow_nx;
  end

endmodule

// File: rtl/lms_adapt_ctrl.sv
// rtl/lms_adapt_ctrl.sv - step-size gear shift, freeze/hold and divergence recovery for a 3-tap LMS
module lms_adapt_ctrl
  import lms_ctrl_pkg::*;
#(
  parameter int                 NB_DATA   = NB_DATA_DEF,
  parameter int                 NB_CNT    = NB_CNT_DEF,
  parameter int                 TRAIN_LEN = TRAIN_LEN_DEF,
  parameter logic [NB_DATA-1:0] MU_TRAIN  = MU_TRAIN_DEF,
  parameter logic [NB_DATA-1:0] MU_TRACK  = MU_TRACK_DEF,
  parameter int                 ALPHA_SH  = ALPHA_SH_DEF,
  parameter logic [NB_DATA-1:0] DIV_THR   = DIV_THR_DEF,
  parameter int                 DIV_CNT   = DIV_CNT_DEF,
  parameter logic [NB_DATA-1:0] CONV_THR  = CONV_THR_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_freeze,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_error,
  output logic [NB_DATA-1:0] o_mu,
  output logic               o_adapt_en,
  output logic               o_coef_clr,
  output logic [1:0]         o_state,
  output logic [NB_DATA-1:0] o_err_pow,
  output logic               o_converged,
  output logic               o_diverged
);

  localparam logic [NB_CNT-1:0] TRAIN_LAST = NB_CNT'(TRAIN_LEN - 1);
  localparam logic [NB_CNT-1:0] DIV_LAST   = NB_CNT'(DIV_CNT - 1);

  state_t              state, state_nx, origin, origin_nx;
  logic [NB_CNT-1:0]   train_cnt, train_nx, div_cnt, div_nx;
  logic [NB_CNT-1:0]   train_inc, div_inc;
  logic                diverged_nx, clr_nx, en_nx;
  logic [NB_DATA-1:0]  mu_nx;

  err_pow_est #(
    .NB_DATA  (NB_DATA),
    .ALPHA_SH (ALPHA_SH)
  ) u_err_pow (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .i_error   (i_error),
    .o_err_pow (o_err_pow)
  );

  assign train_inc = (&train_cnt) ? train_cnt : train_cnt + 1'b1;
  assign div_inc   = (&div_cnt)   ? div_cnt   : div_cnt + 1'b1;

  // Divergence is judged on the error power held before this sample's update
  always_comb begin
    state_nx    = state;
    origin_nx   = origin;
    train_nx    = train_cnt;
    div_nx      = div_cnt;
    diverged_nx = o_diverged;
    clr_nx      = 1'b0;
    if (i_start) begin
      state_nx    = ST_TRAIN;
      clr_nx      = 1'b1;
      train_nx    = '0;
      div_nx      = '0;
      diverged_nx = 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_TRAIN: begin
          if (i_freeze) begin
            state_nx  = ST_HOLD;
            origin_nx = ST_TRAIN;
          end else if (i_valid) begin
            train_nx = train_inc;
            if (train_cnt == TRAIN_LAST) begin
              state_nx = ST_TRACK;
              div_nx   = '0;
            end
          end
        end
        ST_TRACK: begin
          if (i_freeze) begin
            state_nx  = ST_HOLD;
            origin_nx = ST_TRACK;
          end else if (i_valid) begin
            if (o_err_pow > DIV_THR) begin
              div_nx = div_inc;
              if (div_cnt == DIV_LAST) begin
                state_nx    = ST_TRAIN;
                clr_nx      = 1'b1;
                diverged_nx = 1'b1;
                train_nx    = '0;
                div_nx      = '0;
              end
            end else begin
              div_nx = '0;
            end
          end
        end
        ST_HOLD: if (!i_freeze) state_nx = origin;
        default: state_nx = ST_IDLE;
      endcase
    end

    mu_nx = '0;
    en_nx = 1'b0;
    case (state_nx)
      ST_TRAIN: begin mu_nx = MU_TRAIN; en_nx = 1'b1; end
      ST_TRACK: begin mu_nx = MU_TRACK; en_nx = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      origin     <= ST_IDLE;
      train_cnt  <= '0;
      div_cnt    <= '0;
      o_mu       <= '0;
      o_adapt_en <= 1'b0;
      o_coef_clr <= 1'b0;
      o_diverged <= 1'b0;
    end else begin
      state      <= state_nx;
      origin     <= origin_nx;
      train_cnt  <= train_nx;
      div_cnt    <= div_nx;
      o_mu       <= mu_nx;
      o_adapt_en <= en_nx;
      o_coef_clr <= clr_nx;
      o_diverged <= diverged_nx;
    end
  end

  assign o_state     = state;
  assign o_converged = (state == ST_TRACK) && (o_err_pow < CONV_THR);

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// tb/tb_lms_adapt_ctrl.sv - randomized directed bench for lms_adapt_ctrl against a behavioural model
module tb_lms_adapt_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_freeze, i_valid;
  logic [15:0] i_error;
  logic [15:0] o_mu, o_err_pow;
  logic        o_adapt_en, o_coef_clr, o_converged, o_diverged;
  logic [1:0]  o_state;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 train, 2 track, 3 hold
  int m_st, m_org, m_tc, m_dc, m_p, m_clr, m_div;

  always #5 i_clk = ~i_clk;

  lms_adapt_ctrl dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_freeze    (i_freeze),
    .i_valid     (i_valid),
    .i_error     (i_error),
    .o_mu        (o_mu),
    .o_adapt_en  (o_adapt_en),
    .o_coef_clr  (o_coef_clr),
    .o_state     (o_state),
    .o_err_pow   (o_err_pow),
    .o_converged (o_converged),
    .o_diverged  (o_diverged)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int floor_div16(input int d);
    return (d >= 0) ? d / 16 : -((-d + 15) / 16);
  endfunction

  task automatic model(input bit rst, input bit st, input bit fr, input bit va, input logic [15:0] e);
    int p_old, a, nx;
    if (rst) begin
      m_st = 0; m_org = 0; m_tc = 0; m_dc = 0; m_p = 0; m_clr = 0; m_div = 0;
      return;
    end
    p_old = m_p;
    if (va) begin
      a = int'($signed(e));
      if (a < 0) a = -a;
      if (a > 32767) a = 32767;
      nx = m_p + floor_div16(a - m_p);
      m_p = (nx < 0) ? 0 : (nx > 32767) ? 32767 : nx;
    end
    m_clr = 0;
    if (st) begin
      m_st = 1; m_clr = 1; m_tc = 0; m_dc = 0; m_div = 0;
    end else begin
      case (m_st)
        1: if (fr) begin m_org = 1; m_st = 3; end
           else if (va) begin
             m_tc++;
             if (m_tc == 4096) begin m_st = 2; m_dc = 0; end
           end
        2: if (fr) begin m_org = 2; m_st = 3; end
           else if (va) begin
             if (p_old > 16384) begin
               m_dc++;
               if (m_dc == 64) begin m_st = 1; m_clr = 1; m_div = 1; m_tc = 0; m_dc = 0; end
             end else m_dc = 0;
           end
        3: if (!fr) m_st = m_org;
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    int mu;
    mu = (m_st == 1) ? 32'h0666 : (m_st == 2) ? 32'h0148 : 0;
    chk("state", 32'(o_state), m_st);
    chk("mu", 32'(o_mu), mu);
    chk("adapt_en", 32'(o_adapt_en), (m_st == 1 || m_st == 2) ? 1 : 0);
    chk("coef_clr", 32'(o_coef_clr), m_clr);
    chk("err_pow", 32'(o_err_pow), m_p);
    chk("converged", 32'(o_converged), (m_st == 2 && m_p < 32'h0400) ? 1 : 0);
    chk("diverged", 32'(o_diverged), m_div);
  endtask

  task automatic cyc(input bit rst, input bit st, input bit fr, input bit va, input logic [15:0] e);
    i_rst = rst; i_start = st; i_freeze = fr; i_valid = va; i_error = e;
    model(rst, st, fr, va, e);
    @(posedge i_clk);
    #1;
    compare_all();
  endtask

  function automatic logic [15:0] rnd_err(input int lo, input int hi);
    int v;
    v = int'($urandom_range(hi, lo));
    if ($urandom_range(1, 0) == 1) v = -v;
    return 16'(v);
  endfunction

  function automatic bit rnd_valid();
    return $urandom_range(3, 0) != 0;
  endfunction

  initial begin
    int n, trained;
    i_rst = 1'b1; i_start = 1'b0; i_freeze = 1'b0; i_valid = 1'b0; i_error = '0;
    cyc(1, 0, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);
    cyc(0, 0, 1, 1, 16'h1234);

    // Training run with e = 0x0100 into TRACK
    cyc(0, 1, 0, 0, 16'h0);
    n = 0;
    while (m_st != 2 && n < 20000) begin
      cyc(0, 0, 0, rnd_valid(), 16'h0100);
      n++;
    end
    chk("t1_track", 32'(o_state), 2);

    // Small errors in TRACK: converged
    for (int i = 0; i < 200; i++) cyc(0, 0, 0, 1'b1, rnd_err(0, 32));
    chk("t2_converged", 32'(o_converged), 1);

    // Large errors: divergence recovery
    n = 0;
    while (m_div == 0 && n < 400) begin
      cyc(0, 0, 0, rnd_valid(), rnd_err(28672, 32767));
      n++;
    end
    chk("t3_diverged", 32'(o_diverged), 1);
    chk("t3_train", 32'(o_state), 1);

    // Freeze at train_cnt=1000 for 500 valids, then resume
    n = 0;
    while (m_tc < 1000 && n < 5000) begin
      cyc(0, 0, 0, rnd_valid(), rnd_err(0, 2000));
      n++;
    end
    for (int i = 0; i < 500; i++) cyc(0, 0, 1, 1'b1, rnd_err(0, 4000));
    chk("t4_hold", 32'(o_state), 3);
    chk("t4_hold_mu", 32'(o_mu), 0);
    trained = 0;
    n = 0;
    while (m_st != 2 && n < 8000) begin
      i_valid = rnd_valid();
      if (i_valid && o_state == 2'd1) trained++;
      cyc(0, 0, 0, i_valid, rnd_err(0, 2000));
      n++;
    end
    chk("t4_train_valids", 32'(trained), 3096);
    chk("t4_track", 32'(o_state), 2);

    // Most-negative error held in HOLD: power saturates without wrapping
    for (int i = 0; i < 300; i++) cyc(0, 0, 1, 1'b1, 16'h8000);
    chk("t5_sat_range", 32'(o_err_pow >= 16'h7FF0 && o_err_pow <= 16'h7FFF), 1);
    cyc(0, 0, 0, 1'b0, 16'h0);

    // Force diverged, then start with freeze mid-TRACK
    n = 0;
    while (m_div == 0 && n < 400) begin
      cyc(0, 0, 0, 1'b1, 16'h7FFF);
      n++;
    end
    n = 0;
    while (m_st != 2 && n < 8000) begin
      cyc(0, 0, 0, 1'b1, 16'h0);
      n++;
    end
    chk("t6_track_div", 32'({o_state, o_diverged}), 32'b101);
    cyc(0, 1, 1, 1'b1, 16'h0200);
    chk("t6_start_clr", 32'(o_coef_clr), 1);
    cyc(0, 0, 1, 1'b1, 16'h0200);
    chk("t6_hold", 32'(o_state), 3);
    chk("t6_div_clear", 32'(o_diverged), 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, rnd_valid(), rnd_err(0, 4000));
    cyc(1, 0, 0, 1'b1, 16'h4000);
    chk("t6_reset_pow", 32'(o_err_pow), 0);
    cyc(0, 0, 0, 1'b1, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
